mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//  CPU-side initiator for the word-only data memory (single write-enable, 32-bit words).
//  Accepts byte/halfword/word loads and stores, extracts and extends load data by lane, and
//  performs sub-word stores as read-modify-write. Reports misaligned and out-of-range accesses.
//  Sits between the execute stage and the data memory; sole driver of the memory port.
// PARAMETERS
//  READ_LATENCY  1      cycles from mem_address valid to mem_read_data valid (legal 1..3)
//  MEM_BYTES     65536  memory size in bytes; req_addr >= MEM_BYTES is an error
// PORTS
//  clock           in   1   single system clock; all state on rising edge
//  reset           in   1   synchronous, active-high
//  req_valid       in   1   request present
//  req_ready       out  1   1 only in IDLE; transfer when req_valid & req_ready
//  req_write       in   1   1 = store, 0 = load
//  req_size        in   2   00 byte, 01 halfword, 10 word, 11 illegal (error)
//  req_signed      in   1   loads: 1 sign-extend, 0 zero-extend
//  req_addr        in   32  byte address
//  req_wdata       in   32  store data, right-aligned (byte in [7:0], half in [15:0])
//  resp_valid      out  1   one-cycle pulse; request complete
//  resp_err        out  1   valid with resp_valid; 1 = misaligned/illegal size/out of range
//  resp_rdata      out  32  load result, valid with resp_valid; 0 for stores and errors
//  mem_write       out  1   memory write enable
//  mem_address     out  32  byte address, always word-aligned ({addr[31:2],2'b00})
//  mem_write_data  out  32  full word to write
//  mem_read_data   in   32  word from memory
// BEHAVIOUR
//  Reset: state IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0,
//   mem_write=0, mem_address=0, mem_write_data=0. All outputs registered.
//  States: IDLE, READ, WRITE, RESP. Request captured on handshake edge (cycle 0).
//  Error check at acceptance: size 11; half with addr[0]=1; word with addr[1:0]!=0;
//   addr >= MEM_BYTES. Error -> RESP directly, no memory access, resp_err=1.
//  Word store: cycle 1 WRITE (mem_write=1, data=req_wdata); cycle 2 RESP.
//  Load: READ holds address for READ_LATENCY+1 cycles (1..1+L), mem_write=0; data sampled
//   at end of cycle 1+L; RESP at cycle 2+L. L=1: resp at cycle 3.
//  Sub-word store: READ as above; merged word written in WRITE at cycle 2+L; RESP at 3+L.
//  Lanes little-endian: byte lane = addr[1:0] (lane 0 = bits[7:0]); half lane = addr[1]
//   (0 = [15:0]). Merge replaces only the addressed lane; other bits from read word.
//  mem_write high for exactly one cycle per store, never in READ/RESP/IDLE.
//  RESP: resp_valid=1 one cycle, then IDLE. No backpressure on response.
//  req_valid while busy: ignored (req_ready=0); req_* inputs sampled only on handshake.
//  Back-to-back: new request may handshake in the cycle after RESP (IDLE).
//  Reset mid-operation: abort at the reset edge; mem_write=0 and no resp_valid next cycle;
//   a write already performed in WRITE is not undone.
// TESTING
//  Word store 0x0000_0010 <- 0xDEADBEEF, L=1 -> mem_write pulse in cycle 1, resp cycle 2,
//   err=0; word load same address -> resp_rdata=0xDEADBEEF at cycle 3.
//  Byte store 0xA5 to 0x0000_0011 over 0x11223344 -> written word 0x1122A544;
//   signed byte load 0x11 -> 0xFFFFFFA5; unsigned -> 0x000000A5.
//  Half store 0x8001 to 0x0000_0012 over 0x11223344 -> 0x80013344; signed half load
//   -> 0xFFFF8001.
//  Misaligned word load addr 0x0000_0002, half store 0x0000_0001, size 11, addr 0x0001_0000
//   -> resp_valid cycle 1, resp_err=1, rdata=0, mem_write never asserted.
//  req_valid held high during busy -> exactly one transaction per RESP; reset asserted in
//   READ of a sub-word store -> no mem_write, no resp_valid, req_ready=1 after reset.
//  Sweep READ_LATENCY=1,2,3 with load/RMW -> resp at 2+L / 3+L, values unchanged.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Purpose: CPU-side initiator for a word-only data memory; byte/half/word loads and stores,
//          sub-word stores done as read-modify-write, misaligned/illegal/out-of-range errors.
// Latency: error 1 cycle, word store 2, load 2+READ_LATENCY, sub-word store 3+READ_LATENCY
//          (cycles from the handshake edge to the resp_valid cycle).
// Backpressure: req_ready is high only in IDLE; the response is a one-cycle pulse that
//          cannot be stalled.
// Ports:
//   clock, reset                       rising-edge clock, synchronous active-high reset
//   req_valid/req_ready                request handshake; req_* sampled only on handshake
//   req_write, req_size, req_signed    store/load, 00 byte 01 half 10 word 11 illegal, sign-extend
//   req_addr, req_wdata                byte address, right-aligned store data
//   resp_valid, resp_err, resp_rdata   completion pulse, error flag, extended load data
//   mem_write, mem_address             memory write enable, word-aligned byte address
//   mem_write_data, mem_read_data      full-word write data, full-word read data
module mem_access_ctrl #(
  parameter int READ_LATENCY = 1,
  parameter int MEM_BYTES    = 65536
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  localparam logic [1:0]  SZ_BYTE    = 2'b00;
  localparam logic [1:0]  SZ_HALF    = 2'b01;
  localparam logic [1:0]  SZ_WORD    = 2'b10;
  localparam logic [1:0]  SZ_BAD     = 2'b11;
  // READ lasts READ_LATENCY+1 cycles: counter runs 0..READ_LATENCY.
  localparam logic [1:0]  RD_LAST    = 2'(READ_LATENCY);
  localparam logic [32:0] ADDR_LIMIT = 33'(MEM_BYTES);

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [1:0]  lane_q, lane_d;
  // Only sub-word stores use the held data; word stores forward req_wdata directly.
  logic [15:0] wdata_q, wdata_d;

  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        mem_write_q, mem_write_d;
  logic [31:0] mem_address_q, mem_address_d;
  logic [31:0] mem_write_data_q, mem_write_data_d;

  logic        req_err;
  logic [4:0]  lane_shift;
  logic [31:0] lane_mask;
  logic [31:0] store_bits;
  logic [31:0] merged_word;
  logic [31:0] shifted_rd;
  logic [31:0] load_data;

  // Acceptance-time error classification on the raw request.
  always_comb begin
    req_err = 1'b0;
    case (req_size)
      SZ_HALF: req_err = req_addr[0];
      SZ_WORD: req_err = (req_addr[1:0] != 2'b00);
      SZ_BAD:  req_err = 1'b1;
      default: req_err = 1'b0;
    endcase
    if ({1'b0, req_addr} >= ADDR_LIMIT) begin
      req_err = 1'b1;
    end
  end

  // Lane steering from the captured request. Words are aligned, so their shift is zero.
  always_comb begin
    lane_shift  = (size_q == SZ_HALF) ? {lane_q[1], 4'b0000} : {lane_q, 3'b000};
    lane_mask   = (size_q == SZ_HALF) ? (32'h0000_FFFF << lane_shift)
                                      : (32'h0000_00FF << lane_shift);
    store_bits  = (size_q == SZ_HALF) ? ({16'h0000, wdata_q} << lane_shift)
                                      : ({24'h00_0000, wdata_q[7:0]} << lane_shift);
    merged_word = (mem_read_data & ~lane_mask) | store_bits;
    shifted_rd  = mem_read_data >> lane_shift;
    case (size_q)
      SZ_BYTE: load_data = {{24{signed_q & shifted_rd[7]}}, shifted_rd[7:0]};
      SZ_HALF: load_data = {{16{signed_q & shifted_rd[15]}}, shifted_rd[15:0]};
      default: load_data = shifted_rd;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    write_d          = write_q;
    size_d           = size_q;
    signed_d         = signed_q;
    lane_d           = lane_q;
    wdata_d          = wdata_q;
    req_ready_d      = req_ready_q;
    resp_valid_d     = 1'b0;
    resp_err_d       = 1'b0;
    resp_rdata_d     = 32'h0;
    mem_write_d      = 1'b0;
    mem_address_d    = mem_address_q;
    mem_write_data_d = mem_write_data_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d     = req_write;
          size_d      = req_size;
          signed_d    = req_signed;
          lane_d      = req_addr[1:0];
          wdata_d     = req_wdata[15:0];
          req_ready_d = 1'b0;
          if (req_err) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            mem_address_d = {req_addr[31:2], 2'b00};
            if (req_write && (req_size == SZ_WORD)) begin
              state_d          = WRITE;
              mem_write_d      = 1'b1;
              mem_write_data_d = req_wdata;
            end else begin
              state_d = READ;
              cnt_d   = 2'd0;
            end
          end
        end
      end
      READ: begin
        if (cnt_q == RD_LAST) begin
          if (write_q) begin
            state_d          = WRITE;
            mem_write_d      = 1'b1;
            mem_write_data_d = merged_word;
          end else begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_rdata_d = load_data;
          end
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      WRITE: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
      end
      RESP: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= IDLE;
      cnt_q            <= 2'd0;
      write_q          <= 1'b0;
      size_q           <= SZ_BYTE;
      signed_q         <= 1'b0;
      lane_q           <= 2'd0;
      wdata_q          <= 16'h0;
      req_ready_q      <= 1'b1;
      resp_valid_q     <= 1'b0;
      resp_err_q       <= 1'b0;
      resp_rdata_q     <= 32'h0;
      mem_write_q      <= 1'b0;
      mem_address_q    <= 32'h0;
      mem_write_data_q <= 32'h0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      write_q          <= write_d;
      size_q           <= size_d;
      signed_q         <= signed_d;
      lane_q           <= lane_d;
      wdata_q          <= wdata_d;
      req_ready_q      <= req_ready_d;
      resp_valid_q     <= resp_valid_d;
      resp_err_q       <= resp_err_d;
      resp_rdata_q     <= resp_rdata_d;
      mem_write_q      <= mem_write_d;
      mem_address_q    <= mem_address_d;
      mem_write_data_q <= mem_write_data_d;
    end
  end

  assign req_ready      = req_ready_q;
  assign resp_valid     = resp_valid_q;
  assign resp_err       = resp_err_q;
  assign resp_rdata     = resp_rdata_q;
  assign mem_write      = mem_write_q;
  assign mem_address    = mem_address_q;
  assign mem_write_data = mem_write_data_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: three instances with READ_LATENCY 1, 2, 3, each with its own
// word memory whose read data arrives READ_LATENCY cycles after the address.
// Directed table, held-valid, reset-abort and randomized transactions against a byte-level model.
module tb_mem_access_ctrl;
  localparam int NDUT = 3;
  localparam int NREF = 16;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic             reset;
  logic [NDUT-1:0]  req_valid_v;
  logic             req_write;
  logic [1:0]       req_size;
  logic             req_signed;
  logic [31:0]      req_addr;
  logic [31:0]      req_wdata;
  logic [NDUT-1:0]  req_ready_v, resp_valid_v, resp_err_v, mem_write_v;
  logic [31:0]      resp_rdata_v     [NDUT];
  logic [31:0]      mem_address_v    [NDUT];
  logic [31:0]      mem_write_data_v [NDUT];
  logic [31:0]      mem_read_data_v  [NDUT];

  logic             pl_en;
  int               pl_idx;
  logic [13:0]      pl_addr;
  logic [31:0]      pl_data;

  logic [31:0]      ref_mem [NDUT][NREF];

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    logic [31:0] mem [16384];
    logic [31:0] rd_pipe [g+1];

    mem_access_ctrl #(.READ_LATENCY(g + 1), .MEM_BYTES(65536)) u_dut (
      .clock          (clock),
      .reset          (reset),
      .req_valid      (req_valid_v[g]),
      .req_ready      (req_ready_v[g]),
      .req_write      (req_write),
      .req_size       (req_size),
      .req_signed     (req_signed),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .resp_valid     (resp_valid_v[g]),
      .resp_err       (resp_err_v[g]),
      .resp_rdata     (resp_rdata_v[g]),
      .mem_write      (mem_write_v[g]),
      .mem_address    (mem_address_v[g]),
      .mem_write_data (mem_write_data_v[g]),
      .mem_read_data  (mem_read_data_v[g])
    );

    always @(posedge clock) begin
      rd_pipe[0] <= mem[mem_address_v[g][15:2]];
      for (int k = 1; k <= g; k++) rd_pipe[k] <= rd_pipe[k-1];
      if (pl_en && pl_idx == g) mem[pl_addr] <= pl_data;
      else if (mem_write_v[g]) mem[mem_address_v[g][15:2]] <= mem_write_data_v[g];
    end
    assign mem_read_data_v[g] = rd_pipe[g];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- reference model (byte-level arithmetic) ----------------
  function automatic logic model_err(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd3) return 1'b1;
    if (sz == 2'd1 && (a % 2) != 0) return 1'b1;
    if (sz == 2'd2 && (a % 4) != 0) return 1'b1;
    if (a >= 32'd65536) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] word, input logic [1:0] sz,
                                             input logic sg, input logic [31:0] a);
    int nb; int off; longint v; longint span;
    nb   = nbytes(sz);
    off  = int'(a % 4);
    span = longint'(1) << (8 * nb);
    v    = (longint'(word) >> (8 * off)) % span;
    if (sg && nb < 4 && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] word, input logic [1:0] sz,
                                              input logic [31:0] a, input logic [31:0] wd);
    logic [7:0] b [4];
    int nb; int off;
    nb  = nbytes(sz);
    off = int'(a % 4);
    for (int k = 0; k < 4; k++) b[k] = word[8*k +: 8];
    for (int i = 0; i < nb; i++) b[off + i] = wd[8*i +: 8];
    return {b[3], b[2], b[1], b[0]};
  endfunction

  function automatic int model_lat(input int d, input logic w, input logic [1:0] sz,
                                   input logic [31:0] a);
    if (model_err(sz, a)) return 1;
    if (w && sz == 2'd2) return 2;
    return w ? (3 + d + 1) : (2 + d + 1);
  endfunction

  // Issue one request to DUT d (called at a negedge with DUT idle) and check its completion.
  task automatic do_txn(input int d, input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic e_err, input logic [31:0] e_rd, input int e_lat,
                        input int e_nwr, input logic [31:0] e_ww, input string tag);
    int cyc; int nwr; logic got; logic [31:0] ww; logic [31:0] wa;
    req_write  = w;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    req_valid_v = '0;
    req_valid_v[d] = 1'b1;
    @(posedge clock);
    cyc = 0; nwr = 0; got = 1'b0; ww = 32'h0; wa = 32'h0;
    while (cyc < 30 && !got) begin
      @(negedge clock);
      cyc++;
      req_valid_v = '0;
      if (mem_write_v[d]) begin
        nwr++;
        ww = mem_write_data_v[d];
        wa = mem_address_v[d];
      end
      if (resp_valid_v[d]) got = 1'b1;
    end
    chk({tag, " resp_seen"}, 32'(got), 32'd1);
    chk({tag, " latency"}, cyc, e_lat);
    chk({tag, " err"}, 32'(resp_err_v[d]), 32'(e_err));
    chk({tag, " rdata"}, resp_rdata_v[d], e_rd);
    chk({tag, " nwrites"}, nwr, e_nwr);
    if (e_nwr > 0) begin
      chk({tag, " wdata"}, ww, e_ww);
      chk({tag, " waddr"}, wa, {a[31:2], 2'b00});
    end
    @(negedge clock);
    chk({tag, " pulse_end"}, 32'(resp_valid_v[d]), 32'd0);
    chk({tag, " ready_back"}, 32'(req_ready_v[d]), 32'd1);
    if (!model_err(sz, a) && w)
      ref_mem[d][a[5:2]] = model_store(ref_mem[d][a[5:2]], sz, a, wd);
  endtask

  typedef struct {
    int          d;
    logic        w;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] a;
    logic [31:0] wd;
    logic        err;
    logic [31:0] rd;
    int          lat;
    int          nwr;
    logic [31:0] ww;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t mk(input int d, input logic w, input logic [1:0] sz, input logic sg,
                              input logic [31:0] a, input logic [31:0] wd, input logic err,
                              input logic [31:0] rd, input int lat, input int nwr,
                              input logic [31:0] ww);
    vec_t v;
    v.d = d; v.w = w; v.sz = sz; v.sg = sg; v.a = a; v.wd = wd;
    v.err = err; v.rd = rd; v.lat = lat; v.nwr = nwr; v.ww = ww;
    return v;
  endfunction

  initial begin
    int nhs; int nresp; int bad; int lat;
    logic w; logic [1:0] sz; logic sg; logic [31:0] a; logic [31:0] wd;
    logic e_err; logic [31:0] e_rd; logic [31:0] e_ww;
    int r;

    reset = 1'b1; req_valid_v = '0; req_write = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    pl_en = 1'b0; pl_idx = 0; pl_addr = 14'h0; pl_data = 32'h0;

    for (int L = 1; L <= 3; L++) begin
      int d;
      d = L - 1;
      tbl.push_back(mk(d, 1, 2, 0, 32'h10, 32'hDEADBEEF, 0, 32'h0, 2, 1, 32'hDEADBEEF));
      tbl.push_back(mk(d, 0, 2, 0, 32'h10, 32'h0, 0, 32'hDEADBEEF, 2 + L, 0, 32'h0));
      tbl.push_back(mk(d, 1, 2, 0, 32'h10, 32'h11223344, 0, 32'h0, 2, 1, 32'h11223344));
      tbl.push_back(mk(d, 1, 0, 0, 32'h11, 32'h123456A5, 0, 32'h0, 3 + L, 1, 32'h1122A544));
      tbl.push_back(mk(d, 0, 0, 1, 32'h11, 32'h0, 0, 32'hFFFFFFA5, 2 + L, 0, 32'h0));
      tbl.push_back(mk(d, 0, 0, 0, 32'h11, 32'h0, 0, 32'h000000A5, 2 + L, 0, 32'h0));
      tbl.push_back(mk(d, 1, 2, 0, 32'h10, 32'h11223344, 0, 32'h0, 2, 1, 32'h11223344));
      tbl.push_back(mk(d, 1, 1, 0, 32'h12, 32'hABCD8001, 0, 32'h0, 3 + L, 1, 32'h80013344));
      tbl.push_back(mk(d, 0, 1, 1, 32'h12, 32'h0, 0, 32'hFFFF8001, 2 + L, 0, 32'h0));
      tbl.push_back(mk(d, 0, 1, 0, 32'h12, 32'h0, 0, 32'h00008001, 2 + L, 0, 32'h0));
      tbl.push_back(mk(d, 0, 2, 0, 32'h2, 32'h0, 1, 32'h0, 1, 0, 32'h0));
      tbl.push_back(mk(d, 1, 1, 0, 32'h1, 32'hFFFF, 1, 32'h0, 1, 0, 32'h0));
      tbl.push_back(mk(d, 0, 3, 0, 32'h10, 32'h0, 1, 32'h0, 1, 0, 32'h0));
      tbl.push_back(mk(d, 1, 3, 0, 32'h10, 32'h55, 1, 32'h0, 1, 0, 32'h0));
      tbl.push_back(mk(d, 0, 2, 0, 32'h10000, 32'h0, 1, 32'h0, 1, 0, 32'h0));
      tbl.push_back(mk(d, 1, 0, 0, 32'h10003, 32'h77, 1, 32'h0, 1, 0, 32'h0));
    end

    repeat (3) @(negedge clock);
    for (int d = 0; d < NDUT; d++) begin
      chk($sformatf("rst%0d req_ready", d), 32'(req_ready_v[d]), 32'd1);
      chk($sformatf("rst%0d resp_valid", d), 32'(resp_valid_v[d]), 32'd0);
      chk($sformatf("rst%0d resp_err", d), 32'(resp_err_v[d]), 32'd0);
      chk($sformatf("rst%0d resp_rdata", d), resp_rdata_v[d], 32'h0);
      chk($sformatf("rst%0d mem_write", d), 32'(mem_write_v[d]), 32'd0);
      chk($sformatf("rst%0d mem_address", d), mem_address_v[d], 32'h0);
      chk($sformatf("rst%0d mem_write_data", d), mem_write_data_v[d], 32'h0);
    end
    reset = 1'b0;

    for (int d = 0; d < NDUT; d++) begin
      for (int i = 0; i < NREF; i++) begin
        pl_en = 1'b1; pl_idx = d; pl_addr = 14'(i); pl_data = $urandom;
        ref_mem[d][i] = pl_data;
        @(negedge clock);
      end
    end
    pl_en = 1'b0;
    @(negedge clock);

    foreach (tbl[i]) begin
      do_txn(tbl[i].d, tbl[i].w, tbl[i].sz, tbl[i].sg, tbl[i].a, tbl[i].wd, tbl[i].err,
             tbl[i].rd, tbl[i].lat, tbl[i].nwr, tbl[i].ww, $sformatf("vec%0d", i));
    end

    // req_valid held high across busy cycles: one transaction per response, 4-cycle period.
    req_write = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 32'h10; req_wdata = 32'h0;
    req_valid_v = 3'b001;
    nhs = 0; nresp = 0;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (req_valid_v[0] && req_ready_v[0]) nhs++;
      if (resp_valid_v[0]) begin
        nresp++;
        chk("hold rdata", resp_rdata_v[0], ref_mem[0][4]);
      end
      if (mem_write_v[0]) chk("hold no_write", 32'd1, 32'd0);
      if (k == 39) req_valid_v = '0;
      @(negedge clock);
    end
    chk("hold handshakes", nhs, 10);
    chk("hold responses", nresp, 10);

    // Randomized transactions on every latency variant.
    for (int d = 0; d < NDUT; d++) begin
      for (int i = 0; i < 80; i++) begin
        w  = 1'($urandom_range(0, 1));
        sz = 2'($urandom_range(0, 3));
        sg = 1'($urandom_range(0, 1));
        wd = $urandom;
        r  = $urandom_range(0, 9);
        if (r == 0)      a = 32'h10000 + $urandom_range(0, 255);
        else if (r == 1) a = 32'h8000_0000 | $urandom;
        else             a = $urandom_range(0, 63);
        e_err = model_err(sz, a);
        lat   = model_lat(d, w, sz, a);
        e_rd  = 32'h0;
        e_ww  = 32'h0;
        if (!e_err && !w) e_rd = model_load(ref_mem[d][a[5:2]], sz, sg, a);
        if (!e_err && w)  e_ww = model_store(ref_mem[d][a[5:2]], sz, a, wd);
        do_txn(d, w, sz, sg, a, wd, e_err, e_rd, lat, (!e_err && w) ? 1 : 0, e_ww,
               $sformatf("rnd%0d_%0d", d, i));
      end
    end

    // Reset during READ of a sub-word store on the L=3 instance: nothing written, no response.
    req_write = 1'b1; req_size = 2'd0; req_signed = 1'b0; req_addr = 32'h21; req_wdata = 32'h5A;
    req_valid_v = 3'b100;
    @(posedge clock);
    @(negedge clock);
    req_valid_v = '0;
    chk("abort ready_low_busy", 32'(req_ready_v[2]), 32'd0);
    reset = 1'b1;
    @(negedge clock);
    chk("abort mem_write", 32'(mem_write_v[2]), 32'd0);
    chk("abort resp_valid", 32'(resp_valid_v[2]), 32'd0);
    chk("abort req_ready", 32'(req_ready_v[2]), 32'd1);
    chk("abort mem_address", mem_address_v[2], 32'h0);
    reset = 1'b0;
    bad = 0;
    repeat (8) begin
      @(negedge clock);
      if (mem_write_v[2] || resp_valid_v[2]) bad++;
    end
    chk("abort quiet", bad, 0);
    do_txn(2, 0, 2, 0, 32'h20, 32'h0, 0, ref_mem[2][8], 5, 0, 32'h0, "abort readback");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
